ram1_arbiter: RTL and testbench

- Sequences all accesses to the external RAM1 SRAM and shares it between two requesters: instruction fetch (IF) and data memory (MEM).
- Converts single-cycle level requests into multi-cycle SRAM read/write sequences with registered, glitch-free OE/WE/EN strobes.
- MEM has fixed priority; the CPU stall logic consumes ack and busy.

---
 rtl/ram1_arbiter.sv | 134 +++++++++++++
 tb/tb_ram1_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram1_arbiter.sv
// RAM1 SRAM sequencer shared by instruction fetch and data memory.
// MEM has fixed priority; all strobes, address and bus enable are flops.
module ram1_arbiter #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] Ram1Addr,
    inout  wire  [DATA_W-1:0] Ram1Data,
    output logic              Ram1OE,
    output logic              Ram1WE,
    output logic              Ram1EN
);

    typedef enum logic [2:0] {
        IDLE, RD, WSETUP, WSTROBE, WHOLD, ACK
    } state_t;

    localparam logic [7:0] RDW = 8'(RD_WAIT);
    localparam logic [7:0] WRW = 8'(WR_WAIT);

    state_t            state;
    logic [7:0]        cnt;
    logic              gnt_mem;
    logic              drive;
    logic [DATA_W-1:0] wdata_q;

    assign Ram1Data = drive ? wdata_q : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            gnt_mem   <= 1'b0;
            drive     <= 1'b0;
            wdata_q   <= '0;
            Ram1Addr  <= '0;
            Ram1OE    <= 1'b1;
            Ram1WE    <= 1'b1;
            Ram1EN    <= 1'b1;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mem_req) begin
                        gnt_mem  <= 1'b1;
                        Ram1Addr <= mem_addr;
                        wdata_q  <= mem_wdata;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        Ram1EN   <= 1'b0;
                        if (mem_we) begin
                            state <= WSETUP;
                            drive <= 1'b1;
                        end else begin
                            state  <= RD;
                            Ram1OE <= 1'b0;
                        end
                    end else if (if_req) begin
                        gnt_mem  <= 1'b0;
                        Ram1Addr <= if_addr;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        Ram1EN   <= 1'b0;
                        Ram1OE   <= 1'b0;
                        state    <= RD;
                    end
                end
                RD: begin
                    if (cnt == RDW) begin
                        state  <= ACK;
                        Ram1OE <= 1'b1;
                        Ram1EN <= 1'b1;
                        if (gnt_mem) mem_rdata <= Ram1Data;
                        else         if_rdata  <= Ram1Data;
                        mem_ack <= gnt_mem;
                        if_ack  <= ~gnt_mem;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WSETUP: begin
                    state  <= WSTROBE;
                    Ram1WE <= 1'b0;
                    cnt    <= '0;
                end
                WSTROBE: begin
                    if (cnt == WRW) begin
                        state  <= WHOLD;
                        Ram1WE <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WHOLD: begin
                    // only MEM can write, so the ack is always MEM's
                    state   <= ACK;
                    drive   <= 1'b0;
                    Ram1EN  <= 1'b1;
                    mem_ack <= 1'b1;
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram1_arbiter.sv
// Directed bench for ram1_arbiter with a behavioural SRAM model.
// A second instance runs with RD_WAIT=3 and a random access stream.
module tb_ram1_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        if_req, mem_req, mem_we;
    logic [17:0] if_addr, mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] if_rdata1, mem_rdata1;
    logic        if_ack1, mem_ack1, busy1;
    logic [17:0] addr1;
    logic        oe1, we1, en1;
    wire  [15:0] data1;

    logic        if_req2, mem_req2, mem_we2;
    logic [17:0] if_addr2, mem_addr2;
    logic [15:0] mem_wdata2;
    logic [15:0] if_rdata2, mem_rdata2;
    logic        if_ack2, mem_ack2, busy2;
    logic [17:0] addr2;
    logic        oe2, we2, en2;
    wire  [15:0] data2;

    int checks = 0;
    int errors = 0;

    ram1_arbiter u1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata1), .if_ack(if_ack1),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata1), .mem_ack(mem_ack1),
        .busy(busy1), .Ram1Addr(addr1), .Ram1Data(data1),
        .Ram1OE(oe1), .Ram1WE(we1), .Ram1EN(en1)
    );

    ram1_arbiter #(.RD_WAIT(3)) u2 (
        .clk(clk), .rst(rst),
        .if_req(if_req2), .if_addr(if_addr2),
        .if_rdata(if_rdata2), .if_ack(if_ack2),
        .mem_req(mem_req2), .mem_we(mem_we2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .mem_ack(mem_ack2),
        .busy(busy2), .Ram1Addr(addr2), .Ram1Data(data2),
        .Ram1OE(oe2), .Ram1WE(we2), .Ram1EN(en2)
    );

    // undriven bus reads back as all-ones
    pullup (data1);
    pullup (data2);

    logic [15:0] sram [0:1023];
    logic        use_fixed;
    logic [15:0] fixed_val;

    assign data1 = (!oe1 && !en1)
                 ? (use_fixed ? fixed_val : sram[addr1[9:0]])
                 : 16'bz;

    always @(posedge clk)
        if (!we1 && !en1) sram[addr1[9:0]] <= data1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("oe_we_excl1", {31'b0, oe1 | we1}, 1);
        chk("oe_we_excl2", {31'b0, oe2 | we2}, 1);
        if (!oe2) chk("bus2_oe_low", {16'b0, data2}, 32'h0000FFFF);
    endtask

    task automatic acc1(input logic is_mem, input logic wr,
                        input logic [17:0] a, input logic [15:0] d,
                        output int n, output int oel, output int wel,
                        output int drv, output int bsy);
        logic got;
        n = 0; oel = 0; wel = 0; drv = 0; bsy = 0; got = 1'b0;
        if (is_mem) begin
            mem_req = 1'b1; mem_we = wr; mem_addr = a; mem_wdata = d;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            n++;
            if (!oe1) oel++;
            if (!we1) wel++;
            if (oe1 && data1 === d) drv++;
            if (busy1) bsy++;
            if (is_mem ? mem_ack1 : if_ack1) got = 1'b1;
        end
        chk("acc1_ack_seen", {31'b0, got}, 1);
        mem_req = 1'b0; if_req = 1'b0; mem_we = 1'b0;
        step();
    endtask

    int n, oel, wel, drv, bsy;
    int mc, ic, mcyc, icyc;
    logic got;

    initial begin
        rst = 1'b1;
        if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0;
        if_addr = 18'h00055; mem_addr = 18'h00ABC; mem_wdata = '0;
        if_req2 = 1'b0; mem_req2 = 1'b0; mem_we2 = 1'b0;
        if_addr2 = '0; mem_addr2 = '0; mem_wdata2 = '0;
        use_fixed = 1'b1; fixed_val = 16'h5A5A;

        repeat (3) step();
        chk("rst_oe", {31'b0, oe1}, 1);
        chk("rst_we", {31'b0, we1}, 1);
        chk("rst_en", {31'b0, en1}, 1);
        chk("rst_addr", {14'b0, addr1}, 0);
        chk("rst_if_ack", {31'b0, if_ack1}, 0);
        chk("rst_mem_ack", {31'b0, mem_ack1}, 0);
        chk("rst_if_rdata", {16'b0, if_rdata1}, 0);
        chk("rst_mem_rdata", {16'b0, mem_rdata1}, 0);
        chk("rst_busy", {31'b0, busy1}, 0);
        chk("rst_bus_z", {16'b0, data1}, 32'h0000FFFF);

        rst = 1'b0;
        step();
        chk("post_rst_busy", {31'b0, busy1}, 1);
        chk("post_rst_oe", {31'b0, oe1}, 0);
        chk("post_rst_mem_grant", {14'b0, addr1}, 32'h00ABC);
        step(); step();
        chk("post_rst_mem_ack", {31'b0, mem_ack1}, 1);
        chk("post_rst_if_ack", {31'b0, if_ack1}, 0);
        chk("post_rst_mem_rdata", {16'b0, mem_rdata1}, 32'h5A5A);
        mem_req = 1'b0;
        step();
        chk("gap_idle_busy", {31'b0, busy1}, 0);
        step();
        chk("if_grant_addr", {14'b0, addr1}, 32'h00055);
        step(); step();
        chk("if_ack_after", {31'b0, if_ack1}, 1);
        if_req = 1'b0;
        step();

        fixed_val = 16'hA5A5;
        acc1(1'b0, 1'b0, 18'h00100, 16'h0000, n, oel, wel, drv, bsy);
        chk("ifrd_latency", n, 3);
        chk("ifrd_oe_low", oel, 2);
        chk("ifrd_we_low", wel, 0);
        chk("ifrd_busy", bsy, 3);
        chk("ifrd_rdata", {16'b0, if_rdata1}, 32'hA5A5);
        chk("ifrd_idle_busy", {31'b0, busy1}, 0);
        chk("ifrd_mem_rdata_held", {16'b0, mem_rdata1}, 32'h5A5A);

        use_fixed = 1'b0;
        acc1(1'b1, 1'b1, 18'h3FFFF, 16'h1234, n, oel, wel, drv, bsy);
        chk("wr_latency", n, 5);
        chk("wr_we_low", wel, 2);
        chk("wr_oe_low", oel, 0);
        chk("wr_bus_driven", drv, 4);
        chk("wr_bus_z_after", {16'b0, data1}, 32'h0000FFFF);
        acc1(1'b1, 1'b0, 18'h3FFFF, 16'h0000, n, oel, wel, drv, bsy);
        chk("rdback_latency", n, 3);
        chk("rdback_data", {16'b0, mem_rdata1}, 32'h1234);
        chk("rdback_if_rdata_held", {16'b0, if_rdata1}, 32'hA5A5);

        use_fixed = 1'b1; fixed_val = 16'h0F0F;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 18'h00010;
        if_req = 1'b1; if_addr = 18'h00020;
        mc = 0; ic = 0; mcyc = 0; icyc = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (mem_ack1) begin mc++; mcyc = c; mem_req = 1'b0; end
            if (if_ack1)  begin ic++; icyc = c; if_req = 1'b0; end
        end
        chk("arb_mem_count", mc, 1);
        chk("arb_if_count", ic, 1);
        chk("arb_mem_cycle", mcyc, 3);
        chk("arb_if_cycle", icyc, 7);
        mem_req = 1'b0; if_req = 1'b0;

        mem_req = 1'b1; mem_we = 1'b1;
        mem_addr = 18'h00200; mem_wdata = 16'h0BEE;
        step(); step();
        chk("abort_in_strobe", {31'b0, we1}, 0);
        rst = 1'b1;
        step();
        chk("abort_we", {31'b0, we1}, 1);
        chk("abort_en", {31'b0, en1}, 1);
        chk("abort_bus_z", {16'b0, data1}, 32'h0000FFFF);
        chk("abort_busy", {31'b0, busy1}, 0);
        chk("abort_no_ack", {31'b0, mem_ack1}, 0);
        mem_req = 1'b0; mem_we = 1'b0;
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("abort_no_late_ack", {31'b0, mem_ack1}, 0);
        end

        mem_req2 = 1'b1; mem_we2 = 1'b0; mem_addr2 = 18'h00300;
        n = 0; oel = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            n++;
            if (!oe2) oel++;
            if (mem_ack2) got = 1'b1;
        end
        chk("rw3_ack_seen", {31'b0, got}, 1);
        chk("rw3_latency", n, 5);
        chk("rw3_oe_low", oel, 4);
        chk("rw3_rdata_pullup", {16'b0, mem_rdata2}, 32'hFFFF);
        mem_req2 = 1'b0;
        step();

        for (int k = 0; k < 1000; k++) begin
            logic use_if;
            use_if = 1'($urandom_range(0, 1));
            if (use_if) begin
                if_req2 = 1'b1; if_addr2 = 18'($urandom);
            end else begin
                mem_req2 = 1'b1; mem_we2 = 1'($urandom_range(0, 1));
                mem_addr2 = 18'($urandom);
                mem_wdata2 = 16'($urandom) & 16'hFFFE;
            end
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                step();
                if (use_if ? if_ack2 : mem_ack2) got = 1'b1;
            end
            chk("rand_ack_seen", {31'b0, got}, 1);
            if_req2 = 1'b0; mem_req2 = 1'b0; mem_we2 = 1'b0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
